// File: rtl/othello_dir_validator.sv
// Walks one Othello direction through the board RAM and reports whether the player flanks opponent discs.
// Optional macro OTHELLO_VALIDATOR_FLIP_EN adds a FLIP state that writes the captured cells back as own colour.
module othello_dir_validator #(
  parameter int BOARD_W    = 10,
  parameter int BOARD_SIZE = 100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] s_addr_in,
  input  logic       player,
  input  logic [3:0] step_in,
  input  logic       step_neg,
  input  logic       ld,
  input  logic       enable,
  input  logic [1:0] data_in,
  output logic [6:0] addr_out,
  output logic       wren_o,
  output logic [1:0] data_out,
  output logic       dir_status_o,
  output logic       s_done_o
);

  typedef enum logic [2:0] {
    IDLE, READY, REQ, WAIT, CHECK,
`ifdef OTHELLO_VALIDATOR_FLIP_EN
    FLIP,
`endif
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] start_q, start_d;
  logic       player_q, player_d;
  logic [3:0] step_q, step_d;
  logic       neg_q, neg_d;
  logic [6:0] cur_q, cur_d;
  logic [3:0] count_q, count_d;
  logic [6:0] addr_q, addr_d;
  logic       dir_q, dir_d;
  logic       done_q, done_d;

  logic [7:0] fwd;
  logic       fwd_oor;
  logic       step_legal;
  logic [1:0] own, opp;

  // 8-bit arithmetic: a 7-bit borrow wraps above 127, so one compare catches both ends
  function automatic logic [7:0] step_addr(input logic [6:0] a, input logic [3:0] s, input logic neg);
    return neg ? ({1'b0, a} - {4'b0, s}) : ({1'b0, a} + {4'b0, s});
  endfunction

  assign fwd        = step_addr(cur_q, step_q, neg_q);
  assign fwd_oor    = (fwd >= 8'(BOARD_SIZE));
  assign step_legal = (step_q == 4'd1) || (step_q == 4'(BOARD_W - 1)) ||
                      (step_q == 4'(BOARD_W)) || (step_q == 4'(BOARD_W + 1));
  assign own        = player_q ? 2'b10 : 2'b01;
  assign opp        = player_q ? 2'b01 : 2'b10;

`ifdef OTHELLO_VALIDATOR_FLIP_EN
  logic [7:0] back;
  logic       wren_q, wren_d;
  logic [1:0] wdata_q, wdata_d;
  assign back = step_addr(cur_q, step_q, ~neg_q);
`endif

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    player_d = player_q;
    step_d   = step_q;
    neg_d    = neg_q;
    cur_d    = cur_q;
    count_d  = count_q;
    addr_d   = addr_q;
    dir_d    = dir_q;
    done_d   = done_q;
`ifdef OTHELLO_VALIDATOR_FLIP_EN
    wren_d   = 1'b0;
    wdata_d  = 2'b00;
`endif
    if (ld) begin
      start_d  = s_addr_in;
      player_d = player;
      step_d   = step_in;
      neg_d    = step_neg;
      cur_d    = s_addr_in;
      count_d  = 4'd0;
      dir_d    = 1'b0;
      done_d   = 1'b0;
      state_d  = READY;
    end else begin
      case (state_q)
        READY: if (enable) begin
          if (!step_legal || fwd_oor) begin
            dir_d   = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            cur_d   = fwd[6:0];
            addr_d  = fwd[6:0];
            state_d = REQ;
          end
        end
        REQ:  state_d = WAIT;
        WAIT: state_d = CHECK;
        CHECK: begin
          if (data_in == opp) begin
            count_d = count_q + 4'd1;
            if (fwd_oor) begin
              dir_d   = 1'b0;
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              cur_d   = fwd[6:0];
              addr_d  = fwd[6:0];
              state_d = REQ;
            end
          end else if (data_in == own) begin
            dir_d = (count_q != 4'd0);
`ifdef OTHELLO_VALIDATOR_FLIP_EN
            if (count_q != 4'd0) begin
              cur_d   = back[6:0];
              addr_d  = back[6:0];
              wren_d  = 1'b1;
              wdata_d = own;
              state_d = FLIP;
            end else begin
              done_d  = 1'b1;
              state_d = DONE;
            end
`else
            done_d  = 1'b1;
            state_d = DONE;
`endif
          end else begin
            dir_d   = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
`ifdef OTHELLO_VALIDATOR_FLIP_EN
        // count_q is the number of writes still outstanding, including the one on the bus now
        FLIP: begin
          if (count_q > 4'd1) begin
            count_d = count_q - 4'd1;
            cur_d   = back[6:0];
            addr_d  = back[6:0];
            wren_d  = 1'b1;
            wdata_d = own;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      start_q  <= '0;
      player_q <= 1'b0;
      step_q   <= '0;
      neg_q    <= 1'b0;
      cur_q    <= '0;
      count_q  <= '0;
      addr_q   <= '0;
      dir_q    <= 1'b0;
      done_q   <= 1'b0;
`ifdef OTHELLO_VALIDATOR_FLIP_EN
      wren_q   <= 1'b0;
      wdata_q  <= 2'b00;
`endif
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      player_q <= player_d;
      step_q   <= step_d;
      neg_q    <= neg_d;
      cur_q    <= cur_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      dir_q    <= dir_d;
      done_q   <= done_d;
`ifdef OTHELLO_VALIDATOR_FLIP_EN
      wren_q   <= wren_d;
      wdata_q  <= wdata_d;
`endif
    end
  end

  assign addr_out     = addr_q;
  assign dir_status_o = dir_q;
  assign s_done_o     = done_q;
`ifdef OTHELLO_VALIDATOR_FLIP_EN
  assign wren_o   = wren_q;
  assign data_out = wdata_q;
`else
  assign wren_o   = 1'b0;
  assign data_out = 2'b00;
`endif

  // start is latched for completeness of the load; the walk itself tracks cur
  logic unused_ok;
  assign unused_ok = ^start_q;

endmodule

// File: tb/tb_othello_dir_validator.sv
// Self-checking bench for othello_dir_validator with a behavioural 100-word board RAM.
module tb_othello_dir_validator;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] s_addr_in;
  logic       player;
  logic [3:0] step_in;
  logic       step_neg;
  logic       ld;
  logic       enable;
  logic [1:0] data_in;
  logic [6:0] addr_out;
  logic       wren_o;
  logic [1:0] data_out;
  logic       dir_status_o;
  logic       s_done_o;

  othello_dir_validator dut (
    .clock(clock), .reset(reset), .s_addr_in(s_addr_in), .player(player),
    .step_in(step_in), .step_neg(step_neg), .ld(ld), .enable(enable),
    .data_in(data_in), .addr_out(addr_out), .wren_o(wren_o), .data_out(data_out),
    .dir_status_o(dir_status_o), .s_done_o(s_done_o)
  );

  always #5 clock = ~clock;

`ifdef OTHELLO_VALIDATOR_FLIP_EN
  localparam int FLIP = 1;
`else
  localparam int FLIP = 0;
`endif

  function automatic logic [1:0] board_init(input int i);
    int r, c;
    r = i / 10;
    c = i % 10;
    if (r == 0 || r == 9 || c == 0 || c == 9) return 2'b11;
    if (i == 44 || i == 55) return 2'b10;
    if (i == 45 || i == 54) return 2'b01;
    return 2'b00;
  endfunction

  // board RAM: registered address, q one clock later
  logic [1:0] mem [0:99];
  logic [1:0] ram_q;
  logic       init_pulse;
  int         wr_cnt = 0;

  always @(posedge clock) begin
    if (init_pulse) begin
      for (int i = 0; i < 100; i++) mem[i] <= board_init(i);
    end else if (wren_o && addr_out < 7'd100) begin
      mem[addr_out] <= data_out;
      wr_cnt <= wr_cnt + 1;
    end
    ram_q <= (addr_out < 7'd100) ? mem[addr_out] : 2'b11;
  end
  assign data_in = ram_q;

  typedef struct {
    logic       pl;
    logic [6:0] start;
    logic [3:0] step;
    logic       neg;
    int         dir;
    int         lat;
    int         flips;
    int         faddr;
  } vec_t;

  typedef struct {
    int dir;
    int lat;
    int wr;
  } exp_t;

  vec_t vecs[14];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic pl, input logic [6:0] st, input logic [3:0] sp, input logic ng);
    s_addr_in = st;
    player    = pl;
    step_in   = sp;
    step_neg  = ng;
    ld        = 1'b1;
    tick();
    ld        = 1'b0;
  endtask

  task automatic init_board();
    init_pulse = 1'b1;
    tick();
    init_pulse = 1'b0;
  endtask

  initial begin
    int lat, w0;
    logic [6:0] a0;
    exp_t e;

    vecs[0]  = '{1'b0, 7'd43, 4'd1,  1'b0, 1, 7,  1, 44};
    vecs[1]  = '{1'b0, 7'd64, 4'd10, 1'b1, 0, 4,  0, 0};
    vecs[2]  = '{1'b1, 7'd64, 4'd10, 1'b1, 1, 7,  1, 54};
    vecs[3]  = '{1'b0, 7'd64, 4'd10, 1'b0, 0, 4,  0, 0};
    vecs[4]  = '{1'b0, 7'd18, 4'd1,  1'b0, 0, 4,  0, 0};
    vecs[5]  = '{1'b0, 7'd5,  4'd10, 1'b1, 0, 1,  0, 0};
    vecs[6]  = '{1'b0, 7'd43, 4'd3,  1'b0, 0, 1,  0, 0};
    vecs[7]  = '{1'b1, 7'd46, 4'd1,  1'b1, 1, 7,  1, 45};
    vecs[8]  = '{1'b0, 7'd33, 4'd11, 1'b0, 0, 10, 0, 0};
    vecs[9]  = '{1'b1, 7'd36, 4'd9,  1'b0, 0, 10, 0, 0};
    vecs[10] = '{1'b0, 7'd56, 4'd1,  1'b1, 1, 7,  1, 55};
    vecs[11] = '{1'b0, 7'd95, 4'd10, 1'b0, 0, 1,  0, 0};
    vecs[12] = '{1'b1, 7'd22, 4'd11, 1'b0, 0, 4,  0, 0};
    vecs[13] = '{1'b1, 7'd53, 4'd1,  1'b0, 1, 7,  1, 54};

    reset = 1'b1; ld = 1'b0; enable = 1'b0; init_pulse = 1'b0;
    s_addr_in = '0; player = 1'b0; step_in = '0; step_neg = 1'b0;
    init_board();
    tick();
    chk("reset_done", int'(s_done_o), 0);
    chk("reset_dir",  int'(dir_status_o), 0);
    chk("reset_addr", int'(addr_out), 0);
    chk("reset_wren", int'(wren_o), 0);
    reset = 1'b0;
    tick();

    foreach (vecs[k]) begin
      init_board();
      do_load(vecs[k].pl, vecs[k].start, vecs[k].step, vecs[k].neg);
      chk("ld_clears_done", int'(s_done_o), 0);
      w0 = wr_cnt;
      a0 = addr_out;
      sb.push_back('{vecs[k].dir, vecs[k].lat + FLIP * vecs[k].flips, FLIP * vecs[k].flips});
      enable = 1'b1;
      lat = 0;
      do begin
        tick();
        lat++;
      end while (!s_done_o && lat < 40);
      e = sb.pop_front();
      chk("done_seen",  int'(s_done_o), 1);
      chk("dir_status", int'(dir_status_o), e.dir);
      chk("latency",    lat, e.lat);
      tick();
      tick();
      chk("done_hold",  int'(s_done_o), 1);
      chk("dir_hold",   int'(dir_status_o), e.dir);
      enable = 1'b0;
      chk("writes", wr_cnt - w0, e.wr);
      if (vecs[k].lat == 1) chk("no_ram_read", int'(addr_out), int'(a0));
      if (vecs[k].flips != 0)
        chk("flip_cell", int'(mem[vecs[k].faddr]),
            FLIP != 0 ? (vecs[k].pl ? 2 : 1) : int'(board_init(vecs[k].faddr)));
      $display("vec %0d: player=%0d start=%0d step=%s%0d dir=%0d lat=%0d writes=%0d",
               k, vecs[k].pl, vecs[k].start, vecs[k].neg ? "-" : "+", vecs[k].step,
               dir_status_o, lat, wr_cnt - w0);
    end

    // ld and enable together: only the load takes effect
    init_board();
    s_addr_in = 7'd64; player = 1'b0; step_in = 4'd10; step_neg = 1'b0;
    ld = 1'b1; enable = 1'b1;
    tick();
    ld = 1'b0; enable = 1'b0;
    a0 = addr_out;
    for (int i = 0; i < 4; i++) tick();
    chk("ld_prio_done", int'(s_done_o), 0);
    chk("ld_prio_addr", int'(addr_out), int'(a0));
    enable = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!s_done_o && lat < 40);
    enable = 1'b0;
    chk("ld_prio_then_scan_lat", lat, 4);
    chk("ld_prio_then_scan_dir", int'(dir_status_o), 0);
    $display("seq ld+enable: lat=%0d dir=%0d", lat, dir_status_o);

    // reset while waiting on RAM data aborts at once
    init_board();
    do_load(1'b0, 7'd43, 4'd1, 1'b0);
    enable = 1'b1;
    tick();
    tick();
    chk("pre_reset_addr", int'(addr_out), 44);
    reset = 1'b1;
    #1;
    chk("async_rst_addr", int'(addr_out), 0);
    chk("async_rst_done", int'(s_done_o), 0);
    chk("async_rst_wren", int'(wren_o), 0);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("idle_ignores_enable", int'(s_done_o), 0);
    chk("idle_addr", int'(addr_out), 0);
    enable = 1'b0;
    $display("seq reset-in-wait: done=%0d addr=%0d", s_done_o, addr_out);

    // ld from DONE clears the result
    init_board();
    do_load(1'b0, 7'd43, 4'd1, 1'b0);
    enable = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!s_done_o && lat < 40);
    enable = 1'b0;
    chk("capture_dir", int'(dir_status_o), 1);
    do_load(1'b0, 7'd43, 4'd1, 1'b0);
    chk("reload_dir",  int'(dir_status_o), 0);
    chk("reload_done", int'(s_done_o), 0);
    $display("seq reload-from-done: dir=%0d done=%0d", dir_status_o, s_done_o);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
